// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its
// requesters.
package regfile_write_arbiter_pkg;

    localparam int BASIC_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH   = 5;

    typedef logic [BASIC_DATA_WIDTH-1:0] BasicData;
    typedef logic [REG_ADDR_WIDTH-1:0]   RegAddr;

    typedef struct packed {
        logic     valid;
        RegAddr   addr;
        BasicData data;
    } WbReq;

    typedef struct packed {
        logic     wEnable;
        RegAddr   rdAddr;
        BasicData wData;
    } RegWriteReq;

    // Writes to x0 are architecturally discarded.
    localparam RegAddr REG_ZERO = '0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundles the requester handshake and the register-file write port driven by
// the arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

    logic                  wEnable;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] wData;
    logic [IDX_W-1:0]      grant_idx;
    logic                  addr_conflict;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wEnable, rdAddr, wData, grant_idx, addr_conflict
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wEnable, rdAddr, wData, grant_idx, addr_conflict
    );

    // Register-file / decode-bypass view of the registered write.
    modport writeBackStage (
        input wEnable, rdAddr, wData
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins; output is one-hot or all zero.
module regfile_write_arbiter_rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    localparam int PTR_W = $clog2(N);

    logic             found;
    int               sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// requesters using round-robin arbitration and a registered write port.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic                     clk,
    input logic                     rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [ADDR_WIDTH-1:0] reqAddr [NUM_REQ];
    logic [DATA_WIDTH-1:0] reqData [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign reqAddr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign reqData[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [NUM_REQ-1:0]    grantVec;
    logic [IDX_W-1:0]      rrPtr;
    logic [IDX_W-1:0]      winIdx;
    logic [IDX_W-1:0]      nextPtr;
    logic                  anyGrant;
    logic                  conflictNext;

    logic                  wEnableReg;
    logic [ADDR_WIDTH-1:0] rdAddrReg;
    logic [DATA_WIDTH-1:0] wDataReg;
    logic [IDX_W-1:0]      grantIdxReg;
    logic                  conflictReg;

    regfile_write_arbiter_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rrArbiter (
        .req   (bus.req_valid),
        .ptr   (rrPtr),
        .grant (grantVec)
    );

    // Nothing is accepted while reset is held.
    assign bus.req_ready = rst ? grantVec : '0;
    assign anyGrant      = |grantVec;

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVec[i]) begin
                winIdx = IDX_W'(i);
            end
        end
    end

    assign nextPtr = (winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : winIdx + IDX_W'(1);

    // Diagnostic only: any two valid requesters aiming at the same live register.
    always_comb begin
        conflictNext = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (bus.req_valid[i] && bus.req_valid[j] &&
                    (reqAddr[i] == reqAddr[j]) &&
                    (reqAddr[i] != ADDR_WIDTH'(REG_ZERO))) begin
                    conflictNext = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr       <= '0;
            wEnableReg  <= 1'b0;
            rdAddrReg   <= '0;
            wDataReg    <= '0;
            grantIdxReg <= '0;
            conflictReg <= 1'b0;
        end else begin
            conflictReg <= conflictNext;
            if (anyGrant) begin
                rrPtr       <= nextPtr;
                wEnableReg  <= (reqAddr[winIdx] != ADDR_WIDTH'(REG_ZERO));
                rdAddrReg   <= reqAddr[winIdx];
                wDataReg    <= reqData[winIdx];
                grantIdxReg <= winIdx;
            end else begin
                wEnableReg  <= 1'b0;
            end
        end
    end

    assign bus.wEnable       = wEnableReg;
    assign bus.rdAddr        = rdAddrReg;
    assign bus.wData         = wDataReg;
    assign bus.grant_idx     = grantIdxReg;
    assign bus.addr_conflict = conflictReg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with two requesters.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    regfile_write_arbiter_if #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    regfile_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic [1:0] valid,
                          input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
        bus.req_valid = valid;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    task automatic checkPort(input string tag, input logic en, input logic [4:0] addr,
                             input logic [31:0] data, input logic gidx);
        checkVal({tag, ".wEnable"},   64'(bus.wEnable),   64'(en));
        checkVal({tag, ".rdAddr"},    64'(bus.rdAddr),    64'(addr));
        checkVal({tag, ".wData"},     64'(bus.wData),     64'(data));
        checkVal({tag, ".grant_idx"}, 64'(bus.grant_idx), 64'(gidx));
    endtask

    logic [1:0]  rrReady [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0]  rrAddr  [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    logic [31:0] rrData  [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    logic        rrIdx   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        checkCount = 0;
        errorCount = 0;

        // Reset held with random traffic present
        rst = 1'b0;
        setReq(2'b11, 5'($urandom), $urandom, 5'($urandom), $urandom);
        #1;
        checkVal("rst.ready", 64'(bus.req_ready), 64'(0));
        checkPort("rst.port", 1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("rst.conflict", 64'(bus.addr_conflict), 64'(0));
        tick();
        tick();
        checkVal("rst_hold.ready", 64'(bus.req_ready), 64'(0));
        checkPort("rst_hold.port", 1'b0, 5'd0, 32'd0, 1'b0);

        // Release: both valid, round-robin from index 0
        rst = 1'b1;
        setReq(2'b11, 5'd1, 32'h100, 5'd2, 32'h200);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkVal($sformatf("rr%0d.ready", i), 64'(bus.req_ready), 64'(rrReady[i]));
            tick();
            checkPort($sformatf("rr%0d", i), 1'b1, rrAddr[i], rrData[i], rrIdx[i]);
        end

        // Single requester, then idle
        setReq(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1;
        checkVal("single.ready", 64'(bus.req_ready), 64'(2'b01));
        tick();
        checkPort("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        setReq(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        checkPort("idle", 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);

        // x0 write accepted but suppressed
        setReq(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
        #1;
        checkVal("x0.ready", 64'(bus.req_ready), 64'(2'b10));
        tick();
        checkPort("x0", 1'b0, 5'd0, 32'h1234, 1'b1);

        // Same nonzero address from both
        setReq(2'b11, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB);
        #1;
        checkVal("conf.ready", 64'(bus.req_ready), 64'(2'b01));
        tick();
        checkVal("conf.flag", 64'(bus.addr_conflict), 64'(1));
        checkPort("conf.win", 1'b1, 5'd7, 32'hAAAA, 1'b0);
        setReq(2'b10, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB);
        #1;
        checkVal("conf2.ready", 64'(bus.req_ready), 64'(2'b10));
        tick();
        checkVal("conf2.flag", 64'(bus.addr_conflict), 64'(0));
        checkPort("conf2.lose", 1'b1, 5'd7, 32'hBBBB, 1'b1);

        // Both targeting x0: no conflict, no write
        setReq(2'b11, 5'd0, 32'h11, 5'd0, 32'h22);
        tick();
        checkVal("x0conf.flag", 64'(bus.addr_conflict), 64'(0));
        checkPort("x0conf", 1'b0, 5'd0, 32'h11, 1'b0);

        // Pointer now at 1: requester 1 wins first
        setReq(2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
        #1;
        checkVal("ptr1.ready", 64'(bus.req_ready), 64'(2'b10));
        tick();
        checkPort("ptr1", 1'b1, 5'd4, 32'h44, 1'b1);

        // Mid-operation reset drops the in-flight write
        setReq(2'b11, 5'd9, 32'h999, 5'd10, 32'hAAA);
        tick();
        checkPort("pre_rst", 1'b1, 5'd9, 32'h999, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        checkPort("async_rst", 1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("async_rst.ready", 64'(bus.req_ready), 64'(0));
        tick();
        checkPort("rst_edge", 1'b0, 5'd0, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        checkVal("post_rst.ready", 64'(bus.req_ready), 64'(2'b01));
        tick();
        checkPort("post_rst", 1'b1, 5'd9, 32'h999, 1'b0);

        setReq(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        checkVal("final.wEnable", 64'(bus.wEnable), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
